// File: rtl/ip_codma_bus_responder.sv
// ip_codma_bus_responder: pipelined address/data-phase bus target with in-order completion and local word memory
module ip_codma_bus_responder #(
    parameter int OA_DEPTH    = 4,
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      bus_req_i,
    input  logic [31:0]               bus_addr_i,
    input  logic                      bus_write_i,
    output logic                      bus_gnt_o,
    input  logic [31:0]               bus_wdata_i,
    output logic                      bus_dvalid_o,
    output logic [31:0]               bus_rdata_o,
    output logic                      bus_err_o,
    output logic [$clog2(OA_DEPTH):0] oa_count_o
);
    localparam int PW = $clog2(OA_DEPTH);
    localparam int IW = $clog2(MEM_WORDS);
    localparam logic [PW:0] DEPTH = (PW+1)'(OA_DEPTH);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {DP_IDLE, DP_WAIT, DP_ACTIVE} dp_state_t;

    dp_state_t     state_q, state_d;
    logic [3:0]    wait_q, wait_d;
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   count_q;
    logic [IW-1:0] oa_idx [OA_DEPTH];
    logic          oa_write [OA_DEPTH];
    logic          oa_err [OA_DEPTH];
    logic [31:0]   mem [MEM_WORDS];
    logic          push, pop, addr_err, start;
    logic          unused_addr;

    assign unused_addr  = ^bus_addr_i[1:0];
    assign addr_err     = bus_addr_i[31:2] >= 30'(MEM_WORDS);
    assign bus_gnt_o    = !reset_i && (count_q < DEPTH);
    assign push         = bus_req_i && bus_gnt_o;
    assign pop          = (state_q == DP_ACTIVE) && !reset_i;
    assign bus_dvalid_o = pop;
    assign bus_err_o    = pop && oa_err[rptr_q];
    assign bus_rdata_o  = (pop && !oa_write[rptr_q] && !oa_err[rptr_q]) ? mem[oa_idx[rptr_q]] : '0;
    assign oa_count_o   = count_q;
    // chain straight into the next data phase when another entry is (or is becoming) queued
    assign start        = ((state_q == DP_IDLE) && |count_q) || (pop && (|count_q[PW:1] || push));

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        if (state_q == DP_WAIT) begin
            wait_d  = wait_q - 4'd1;
            state_d = (wait_q == '0) ? DP_ACTIVE : DP_WAIT;
        end else if (start) begin
            state_d = (WAIT_CYCLES > 0) ? DP_WAIT : DP_ACTIVE;
            wait_d  = WAIT_LD;
        end else if (state_q == DP_ACTIVE) begin
            state_d = DP_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= DP_IDLE;
            wait_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            wptr_q  <= wptr_q + PW'(push);
            rptr_q  <= rptr_q + PW'(pop);
            count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            oa_idx[wptr_q]   <= bus_addr_i[IW+1:2];
            oa_write[wptr_q] <= bus_write_i;
            oa_err[wptr_q]   <= addr_err;
        end
        if (pop && oa_write[rptr_q] && !oa_err[rptr_q])
            mem[oa_idx[rptr_q]] <= bus_wdata_i;
    end
endmodule

// File: tb/tb_ip_codma_bus_responder.sv
// tb_ip_codma_bus_responder: three responders (WAIT 0/3/1) against a completion-time model plus literal checks
module tb_ip_codma_bus_responder;
    logic        clk = 0, rst;
    logic [2:0]  req;
    logic [31:0] addr, wdata, cur_wd;
    logic        wr;
    logic        gnt [3], dv [3], er [3];
    logic [31:0] rd [3];
    logic [2:0]  cnt [3];

    always #5 clk = ~clk;

    ip_codma_bus_responder #(.OA_DEPTH(4), .MEM_WORDS(256), .WAIT_CYCLES(0)) u0 (
        .clk_i(clk), .reset_i(rst), .bus_req_i(req[0]), .bus_addr_i(addr), .bus_write_i(wr),
        .bus_gnt_o(gnt[0]), .bus_wdata_i(wdata), .bus_dvalid_o(dv[0]), .bus_rdata_o(rd[0]),
        .bus_err_o(er[0]), .oa_count_o(cnt[0]));
    ip_codma_bus_responder #(.OA_DEPTH(4), .MEM_WORDS(256), .WAIT_CYCLES(3)) u1 (
        .clk_i(clk), .reset_i(rst), .bus_req_i(req[1]), .bus_addr_i(addr), .bus_write_i(wr),
        .bus_gnt_o(gnt[1]), .bus_wdata_i(wdata), .bus_dvalid_o(dv[1]), .bus_rdata_o(rd[1]),
        .bus_err_o(er[1]), .oa_count_o(cnt[1]));
    ip_codma_bus_responder #(.OA_DEPTH(4), .MEM_WORDS(256), .WAIT_CYCLES(1)) u2 (
        .clk_i(clk), .reset_i(rst), .bus_req_i(req[2]), .bus_addr_i(addr), .bus_write_i(wr),
        .bus_gnt_o(gnt[2]), .bus_wdata_i(wdata), .bus_dvalid_o(dv[2]), .bus_rdata_o(rd[2]),
        .bus_err_o(er[2]), .oa_count_o(cnt[2]));

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    endtask

    function automatic int wc(int d);
        return (d == 0) ? 0 : (d == 1) ? 3 : 1;
    endfunction

    // model: each accepted phase gets a completion cycle; it occupies the queue until then
    int          qc [3][32];
    logic [31:0] qa [3][32], qd [3][32];
    logic        qw [3][32];
    int          hd [3], tl [3], last_c [3];
    logic [31:0] mm [3][256];
    bit          acc [3];
    bit          chk_en = 0;
    typedef struct { int c; logic [31:0] r; logic e; } ev_t;
    ev_t         ev [$];
    logic [2:0]  cnt_log [8192];
    logic        gnt_log [8192];

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                int n, h, t;
                logic ed, ee, eg;
                logic [31:0] erd;
                n   = tl[d] - hd[d];
                h   = hd[d] % 32;
                ed  = !rst && n > 0 && qc[d][h] == cyc;
                ee  = ed && qa[d][h][31:2] >= 30'd256;
                erd = (ed && !qw[d][h] && !ee) ? mm[d][qa[d][h][9:2]] : 32'h0;
                eg  = !rst && n < 4;
                chk($sformatf("gnt%0d", d), 32'(gnt[d]), 32'(eg));
                chk($sformatf("dvalid%0d", d), 32'(dv[d]), 32'(ed));
                chk($sformatf("err%0d", d), 32'(er[d]), 32'(ee));
                chk($sformatf("rdata%0d", d), rd[d], erd);
                chk($sformatf("count%0d", d), 32'(cnt[d]), n);
                if (dv[d] === 1'b1) ev.push_back('{cyc, rd[d], er[d]});
                if (d == 1 && cyc < 8192) begin
                    cnt_log[cyc] = cnt[1];
                    gnt_log[cyc] = gnt[1];
                end
                acc[d] = 0;
                if (rst) begin
                    hd[d] = 0;
                    tl[d] = 0;
                    last_c[d] = -100;
                end else begin
                    if (ed) begin
                        if (qw[d][h] && !ee) mm[d][qa[d][h][9:2]] = wdata;
                        hd[d]++;
                    end
                    if (req[d] && eg) begin
                        t = tl[d] % 32;
                        qc[d][t] = (cyc <= last_c[d]) ? last_c[d] + wc(d) + 1 : cyc + 2 + wc(d);
                        last_c[d] = qc[d][t];
                        qa[d][t] = addr;
                        qw[d][t] = wr;
                        qd[d][t] = cur_wd;
                        tl[d]++;
                        acc[d] = 1;
                    end
                end
            end
        end
    end

    // write data is presented only in the completing cycle; other cycles carry junk
    task automatic tick();
        @(posedge clk); #1;
        wdata = 32'hBAD0_0000 | 32'(cyc);
        for (int d = 0; d < 3; d++) begin
            int h;
            h = hd[d] % 32;
            if (tl[d] != hd[d] && qc[d][h] == cyc && qw[d][h]) wdata = qd[d][h];
        end
    endtask

    task automatic idle(int n);
        req = 3'b000;
        repeat (n) tick();
    endtask

    task automatic issue(int d, logic w, logic [31:0] a, logic [31:0] data);
        bit done;
        done = 0;
        req = 3'b000;
        req[d] = 1'b1;
        addr = a;
        wr = w;
        cur_wd = data;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk); #1;
            done = acc[d];
            tick();
        end
        req = 3'b000;
        if (!done) begin
            n_chk++;
            $display("FAIL grant_timeout dut%0d: no grant in 64 cycles, required a grant", d);
        end
    endtask

    initial begin
        #500000;
        n_chk++;
        $display("FAIL watchdog: time limit reached, required test completion");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        int c0;
        rst = 1; req = 3'b000; addr = 0; wr = 0; wdata = 0; cur_wd = 0;
        tick();
        chk_en = 1;
        @(negedge clk);
        chk("rst_gnt0", 32'(gnt[0]), 0);
        chk("rst_cnt0", 32'(cnt[0]), 0);
        chk("rst_dvalid0", 32'(dv[0]), 0);
        tick();
        rst = 0;
        // write then read the same word, WAIT=0
        issue(0, 1, 32'h10, 32'hA5A5_0001);
        issue(0, 0, 32'h10, 32'h0);
        @(negedge clk);
        chk("t1_wr_dvalid", 32'(dv[0]), 1);
        chk("t1_wr_rdata", rd[0], 0);
        tick();
        @(negedge clk);
        chk("t1_rd_dvalid", 32'(dv[0]), 1);
        chk("t1_rd_rdata", rd[0], 32'hA5A5_0001);
        idle(3);
        // out-of-range accesses
        ev.delete();
        issue(0, 1, 32'h0, 32'h1234_5678);
        issue(0, 0, 32'h400, 32'h0);
        issue(0, 1, 32'h400, 32'hDEAD_BEEF);
        issue(0, 0, 32'h0, 32'h0);
        idle(8);
        chk("t3_events", ev.size(), 4);
        if (ev.size() == 4) begin
            chk("t3_wr_ok_err", 32'(ev[0].e), 0);
            chk("t3_rd_oob_err", 32'(ev[1].e), 1);
            chk("t3_rd_oob_data", ev[1].r, 0);
            chk("t3_wr_oob_err", 32'(ev[2].e), 1);
            chk("t3_mem0_kept", ev[3].r, 32'h1234_5678);
        end
        // WAIT=3: fill, saturate and drain the queue
        for (int i = 0; i < 6; i++) issue(1, 1, 32'h20 + 32'(4 * i), 32'h1000 + 32'(i));
        idle(30);
        ev.delete();
        for (int i = 0; i < 6; i++) issue(1, 0, 32'h20 + 32'(4 * i), 32'h0);
        idle(30);
        chk("t2_events", ev.size(), 6);
        if (ev.size() == 6) begin
            for (int i = 0; i < 6; i++) chk($sformatf("t2_rdata%0d", i), ev[i].r, 32'h1000 + 32'(i));
            for (int i = 1; i < 6; i++) chk($sformatf("t2_spacing%0d", i), ev[i].c - ev[i-1].c, 4);
            c0 = ev[0].c;
            chk("t4_cnt_at_pop", 32'(cnt_log[c0]), 4);
            chk("t4_gnt_at_pop", 32'(gnt_log[c0]), 0);
            chk("t4_cnt_after", 32'(cnt_log[c0+1]), 3);
            chk("t4_gnt_after", 32'(gnt_log[c0+1]), 1);
            chk("t4_cnt_refill", 32'(cnt_log[c0+2]), 4);
        end
        // reset with three phases queued and the FSM waiting
        issue(1, 0, 32'h20, 32'h0);
        issue(1, 0, 32'h24, 32'h0);
        issue(1, 0, 32'h28, 32'h0);
        rst = 1;
        ev.delete();
        @(negedge clk);
        chk("t5_cnt_before", 32'(cnt[1]), 3);
        tick();
        rst = 0;
        @(negedge clk);
        chk("t5_cnt_after", 32'(cnt[1]), 0);
        chk("t5_gnt_after", 32'(gnt[1]), 1);
        idle(12);
        chk("t5_no_dvalid", ev.size(), 0);
        issue(1, 0, 32'h20, 32'h0);
        idle(8);
        chk("t5_events", ev.size(), 1);
        if (ev.size() == 1) chk("t5_mem_kept", ev[0].r, 32'h1000);
        // WAIT=1: write/read pairs wrapping the pointers
        ev.delete();
        for (int i = 0; i < 20; i++) begin
            issue(2, 1, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i * 32'h111));
            issue(2, 0, 32'h100 + 32'(4 * i), 32'h0);
        end
        idle(16);
        chk("t6_events", ev.size(), 40);
        if (ev.size() == 40)
            for (int i = 0; i < 20; i++)
                chk($sformatf("t6_rdata%0d", i), ev[2*i+1].r, 32'hC0DE_0000 + 32'(i * 32'h111));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
